// File: rtl/title_pkg.sv
// Shared title-screen constants and sequencer state type, used by the bitmap
// generator, the renderer and the title sequencer.
package title_pkg;

    localparam int unsigned TITLE_WIDTH  = 28;
    localparam int unsigned TITLE_HEIGHT = 6;

    typedef enum logic [1:0] {
        REVEAL,
        PROMPT,
        LAUNCH,
        DONE
    } title_state_t;

endpackage

// File: rtl/title_tick_div.sv
// Frame-tick prescaler: tc pulses on every TICKS-th tick_in while clear is low.
module title_tick_div #(
    parameter int unsigned TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick_in,
    output logic tc
);

    localparam int unsigned CntW = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tc = tick_in & ~clear & (cnt_q == CntW'(TICKS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick_in) begin
            cnt_d = tc ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/title_seq_ctrl.sv
// Title screen sequencer: column reveal, blinking prompt, start handoff and
// registered bitmap lookup gated by reveal progress.
module title_seq_ctrl
    import title_pkg::*;
#(
    parameter int unsigned TITLE_WIDTH  = title_pkg::TITLE_WIDTH,
    parameter int unsigned TITLE_HEIGHT = title_pkg::TITLE_HEIGHT,
    parameter int unsigned REVEAL_TICKS = 4,
    parameter int unsigned BLINK_TICKS  = 30
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  frame_tick,
    input  logic                                  start_btn,
    input  logic                                  restart,
    input  logic [TITLE_WIDTH*TITLE_HEIGHT-1:0]   title_in,
    input  logic [$clog2(TITLE_WIDTH)-1:0]        blk_x,
    input  logic [$clog2(TITLE_HEIGHT)-1:0]       blk_y,
    output logic                                  blk_on,
    output logic [$clog2(TITLE_WIDTH+1)-1:0]      reveal_col,
    output logic                                  prompt_on,
    output logic                                  title_active,
    output logic                                  game_start
);

    localparam int unsigned CW = $clog2(TITLE_WIDTH + 1);
    localparam int unsigned IW = $clog2(TITLE_WIDTH * TITLE_HEIGHT);

    title_state_t  state_q, state_d;
    logic [CW-1:0] reveal_col_q, reveal_col_d;
    logic          prompt_on_q, prompt_on_d;
    logic          start_q, start_d;
    logic          blk_on_q, blk_on_d;

    logic          start_rise;
    logic          tick_gated;
    logic          reveal_tc;
    logic          blink_tc;

    assign start_d    = start_btn;
    assign start_rise = start_btn & ~start_q;
    // A start press consumes the cycle; a coincident frame tick is dropped.
    assign tick_gated = frame_tick & ~start_rise;

    // Each divider is held clear outside its own state, so it starts at zero on entry.
    title_tick_div #(
        .TICKS (REVEAL_TICKS)
    ) u_reveal_div (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != REVEAL),
        .tick_in (tick_gated),
        .tc      (reveal_tc)
    );

    title_tick_div #(
        .TICKS (BLINK_TICKS)
    ) u_blink_div (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != PROMPT),
        .tick_in (tick_gated),
        .tc      (blink_tc)
    );

    always_comb begin
        state_d      = state_q;
        reveal_col_d = reveal_col_q;
        prompt_on_d  = prompt_on_q;
        case (state_q)
            REVEAL: begin
                if (start_rise) begin
                    reveal_col_d = CW'(TITLE_WIDTH);
                    prompt_on_d  = 1'b1;
                    state_d      = PROMPT;
                end else if (reveal_tc) begin
                    reveal_col_d = reveal_col_q + CW'(1);
                    if (reveal_col_q == CW'(TITLE_WIDTH - 1)) begin
                        prompt_on_d = 1'b1;
                        state_d     = PROMPT;
                    end
                end
            end
            PROMPT: begin
                if (start_rise) begin
                    state_d = LAUNCH;
                end else if (blink_tc) begin
                    prompt_on_d = ~prompt_on_q;
                end
            end
            LAUNCH: begin
                reveal_col_d = '0;
                prompt_on_d  = 1'b0;
                state_d      = DONE;
            end
            DONE: begin
                if (restart) begin
                    state_d = REVEAL;
                end
            end
            default: state_d = REVEAL;
        endcase
    end

    // Out-of-range coordinates are forced to index 0 so the select stays inside the vector.
    logic          in_range;
    logic [IW-1:0] blk_idx;
    logic [IW-1:0] blk_idx_safe;

    always_comb begin
        in_range     = (IW'(blk_x) < IW'(TITLE_WIDTH)) && (IW'(blk_y) < IW'(TITLE_HEIGHT));
        blk_idx      = IW'(blk_x) + IW'(TITLE_WIDTH) * IW'(blk_y);
        blk_idx_safe = in_range ? blk_idx : '0;
        blk_on_d     = (state_q != DONE) && (IW'(blk_x) < IW'(reveal_col_q)) && in_range
                       && title_in[blk_idx_safe];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= REVEAL;
            reveal_col_q <= '0;
            prompt_on_q  <= 1'b0;
            start_q      <= 1'b0;
            blk_on_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            reveal_col_q <= reveal_col_d;
            prompt_on_q  <= prompt_on_d;
            start_q      <= start_d;
            blk_on_q     <= blk_on_d;
        end
    end

    assign blk_on       = blk_on_q;
    assign reveal_col   = reveal_col_q;
    assign prompt_on    = prompt_on_q;
    assign title_active = (state_q != DONE);
    assign game_start   = (state_q == LAUNCH);

endmodule

// File: doc/title_seq_ctrl.md
# title_seq_ctrl

Sequences the Tetris title screen: progressively reveals the hard-coded title bitmap column by column, blinks the "press start" prompt, and hands control to the game on a start press. It sits between the title bitmap generator and the block renderer. It answers per-block "is this title block lit" queries, gated by the reveal progress. It also issues the one-cycle `game_start` pulse to the game FSM and re-arms on `restart` after game over.

## Interface
Parameters:
- `TITLE_WIDTH`, 28, title bitmap columns
- `TITLE_HEIGHT`, 6, title bitmap rows
- `REVEAL_TICKS`, 4, frame ticks per revealed column
- `BLINK_TICKS`, 30, frame ticks per prompt half-period

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `frame_tick`  in  1  one-cycle pulse per video frame
- `start_btn`  in  1  synchronized start button, level
- `restart`  in  1  one-cycle pulse from game FSM on game over
- `title_in`  in  TITLE_WIDTH*TITLE_HEIGHT  bitmap; bit `x + TITLE_WIDTH*y` is block (x,y)
- `blk_x`  in  $clog2(TITLE_WIDTH)  query column
- `blk_y`  in  $clog2(TITLE_HEIGHT)  query row
- `blk_on`  out  1  queried block is lit (registered)
- `reveal_col`  out  $clog2(TITLE_WIDTH+1)  number of columns currently revealed
- `prompt_on`  out  1  prompt text visible
- `title_active`  out  1  title screen owns the display
- `game_start`  out  1  one-cycle pulse: begin game

## Operation
- States: REVEAL, PROMPT, LAUNCH, DONE.
- Start edge: `start_rise = start_btn & ~start_q`, where `start_q` is `start_btn` delayed one cycle. Only rising edges act.
- Tick counter `tick_cnt` counts `frame_tick` pulses. It is cleared on every state entry and on every terminal count.
- REVEAL:
  - On each REVEAL_TICKS-th frame tick, `reveal_col` increments.
  - When `reveal_col` reaches TITLE_WIDTH, go to PROMPT with `prompt_on`=1.
  - `start_rise` skips ahead: `reveal_col`=TITLE_WIDTH, `prompt_on`=1, go to PROMPT.
- PROMPT:
  - `prompt_on` toggles on each BLINK_TICKS-th frame tick.
  - `start_rise` goes to LAUNCH.
- LAUNCH: lasts exactly one cycle. `game_start`=1, then go to DONE.
- DONE:
  - `title_active`=0, `prompt_on`=0, `reveal_col`=0.
  - `restart` goes to REVEAL with `title_active`=1.
  - `restart` in any other state is ignored.
- Lookup: `blk_on` <= `title_active & (blk_x < reveal_col) & in_range & title_in[blk_x + TITLE_WIDTH*blk_y]`. `in_range` = (`blk_x` < TITLE_WIDTH) & (`blk_y` < TITLE_HEIGHT). Out-of-range coordinates return 0 and never index past the vector.
- Index arithmetic is done at $clog2(TITLE_WIDTH*TITLE_HEIGHT) width, with no truncation.
- Simultaneous events:
  - `start_rise` and `frame_tick` in the same cycle: start wins, and the tick is dropped.
  - `restart` during LAUNCH: ignored.

## Timing
- Reset (async assert, sync deassert by the system):
  - state=REVEAL, `reveal_col`=0, `prompt_on`=0, `title_active`=1, `game_start`=0, `blk_on`=0, `tick_cnt`=0, `start_q`=0.
- Reset asserted mid-operation returns all outputs to the values above immediately.
- `blk_on` latency: 1 cycle from `blk_x`/`blk_y`/`title_in`.
- `reveal_col` updates on the cycle after the qualifying `frame_tick`.
- A full reveal takes TITLE_WIDTH*REVEAL_TICKS frame ticks.
- `start_rise` to `game_start`, from PROMPT: `game_start` is high on the 2nd clock edge after the press cycle. It is never high for more than 1 cycle.
- `title_active` falls on the same edge that `game_start` falls (entry to DONE).
- A held `start_btn` produces exactly one event. A press that skips the reveal does not also launch the game; a new rising edge is required.

## Structure
- Shared package `title_pkg`:
  - `TITLE_WIDTH`/`TITLE_HEIGHT` constants (shared with the bitmap generator and renderer).
  - `title_state_t` enum {REVEAL, PROMPT, LAUNCH, DONE}.
- Sub-module `title_tick_div`:
  - Parameterized frame-tick prescaler with `clk`, `reset`, `clear`, `tick_in`, and a terminal-count `tc` output.
  - Instantiated twice: once for reveal (REVEAL_TICKS) and once for blink (BLINK_TICKS).
- Top holds the FSM, the start edge detector and the registered lookup.

## Test plan
- Reset, then 4 frame ticks (REVEAL_TICKS=4): `reveal_col`=1. After 112 ticks: `reveal_col`=28, state PROMPT, `prompt_on`=1.
- In PROMPT, 30 frame ticks → `prompt_on`=0; 30 more → `prompt_on`=1.
- Press start at `reveal_col`=5 → next cycle `reveal_col`=28, PROMPT, `game_start` stays 0. Holding `start_btn` high for 100 cycles causes no launch.
- In PROMPT, press start → `game_start`=1 for exactly 1 cycle, 2 edges later. `title_active`=0 afterward. `restart` pulse → REVEAL, `reveal_col`=0, `title_active`=1.
- Bitmap with bits (2,1) and (27,5) set, `reveal_col`=3:
  - Query (2,1) → `blk_on`=1 one cycle later.
  - (27,5) → 0.
  - (28,0) and (0,6) → 0.
  - After full reveal, (27,5) → 1.
- Assert `reset` in PROMPT and in LAUNCH → outputs match reset values within the same cycle. `game_start` is never asserted after reset.
